iob_native_axil_bridge: RTL and testbench

IOB_NATIVE_AXIL_BRIDGE -- requirements
Module: iob_native_axil_bridge

---
 rtl/iob_native_axil_bridge.sv | 167 ++++++++++++++++
 tb/tb_iob_native_axil_bridge.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_native_axil_bridge.sv
// rtl/iob_native_axil_bridge.sv - native valid/ready request bus to AXI4-Lite master bridge
module iob_native_axil_bridge #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                valid,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] wstrb,
   output logic [DATA_W-1:0]   rdata,
   output logic                ready,
   output logic                resp_err,
   output logic                m_axi_awvalid,
   input  logic                m_axi_awready,
   output logic [ADDR_W-1:0]   m_axi_awaddr,
   output logic                m_axi_wvalid,
   input  logic                m_axi_wready,
   output logic [DATA_W-1:0]   m_axi_wdata,
   output logic [DATA_W/8-1:0] m_axi_wstrb,
   input  logic                m_axi_bvalid,
   output logic                m_axi_bready,
   input  logic [1:0]          m_axi_bresp,
   output logic                m_axi_arvalid,
   input  logic                m_axi_arready,
   output logic [ADDR_W-1:0]   m_axi_araddr,
   input  logic                m_axi_rvalid,
   output logic                m_axi_rready,
   input  logic [DATA_W-1:0]   m_axi_rdata,
   input  logic [1:0]          m_axi_rresp
);

   localparam int STRB_W = DATA_W / 8;
   localparam int OFF_W  = (DATA_W == 64) ? 3 : 2;
   // Clears the byte-offset bits so AXI sees word-aligned addresses.
   localparam logic [ADDR_W-1:0] ADDR_MASK = {ADDR_W{1'b1}} << OFF_W;

   typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, ACK} state_t;

   state_t              state;
   state_t              state_nxt;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [STRB_W-1:0]   wstrb_q;
   logic                aw_done;
   logic                w_done;
   logic                aw_hs;
   logic                w_hs;

   assign aw_hs        = m_axi_awvalid & m_axi_awready;
   assign w_hs         = m_axi_wvalid & m_axi_wready;
   assign m_axi_awaddr = addr_q;
   assign m_axi_araddr = addr_q;
   assign m_axi_wdata  = wdata_q;
   assign m_axi_wstrb  = wstrb_q;

   // State register; reset abandons any in-flight AXI transfer.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and AXI channel handshake outputs decoded from the current state.
   always_comb begin
      state_nxt     = state;
      m_axi_awvalid = 1'b0;
      m_axi_wvalid  = 1'b0;
      m_axi_bready  = 1'b0;
      m_axi_arvalid = 1'b0;
      m_axi_rready  = 1'b0;
      case (state)
         IDLE: begin
            if (valid) begin
               state_nxt = (|wstrb) ? WADDR : RADDR;
            end
         end
         WADDR: begin
            // AW and W retire independently; leave only once both have handshaken.
            m_axi_awvalid = ~aw_done;
            m_axi_wvalid  = ~w_done;
            if ((aw_done | m_axi_awready) & (w_done | m_axi_wready)) begin
               state_nxt = WRESP;
            end
         end
         WRESP: begin
            m_axi_bready = 1'b1;
            if (m_axi_bvalid) begin
               state_nxt = ACK;
            end
         end
         RADDR: begin
            m_axi_arvalid = 1'b1;
            if (m_axi_arready) begin
               state_nxt = RDATA;
            end
         end
         RDATA: begin
            m_axi_rready = 1'b1;
            if (m_axi_rvalid) begin
               state_nxt = ACK;
            end
         end
         ACK: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Request capture, channel-done tracking, response capture and the ready pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_q   <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
         aw_done  <= 1'b0;
         w_done   <= 1'b0;
         rdata    <= '0;
         resp_err <= 1'b0;
         ready    <= 1'b0;
      end else begin
         ready <= (state_nxt == ACK);
         case (state)
            IDLE: begin
               if (valid) begin
                  addr_q  <= addr & ADDR_MASK;
                  wdata_q <= wdata;
                  wstrb_q <= wstrb;
                  aw_done <= 1'b0;
                  w_done  <= 1'b0;
               end
            end
            WADDR: begin
               if (aw_hs) begin
                  aw_done <= 1'b1;
               end
               if (w_hs) begin
                  w_done <= 1'b1;
               end
            end
            WRESP: begin
               if (m_axi_bvalid) begin
                  resp_err <= |m_axi_bresp;
               end
            end
            RDATA: begin
               if (m_axi_rvalid) begin
                  rdata    <= m_axi_rdata;
                  resp_err <= |m_axi_rresp;
               end
            end
            ACK: begin
               resp_err <= 1'b0;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_iob_native_axil_bridge.sv
// tb/tb_iob_native_axil_bridge.sv - scoreboard bench for the native to AXI4-Lite bridge
module tb_iob_native_axil_bridge;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic [31:0] rdata;
   logic        ready;
   logic        resp_err;
   logic        m_axi_awvalid, m_axi_awready;
   logic [31:0] m_axi_awaddr;
   logic        m_axi_wvalid, m_axi_wready;
   logic [31:0] m_axi_wdata;
   logic [3:0]  m_axi_wstrb;
   logic        m_axi_bvalid, m_axi_bready;
   logic [1:0]  m_axi_bresp;
   logic        m_axi_arvalid, m_axi_arready;
   logic [31:0] m_axi_araddr;
   logic        m_axi_rvalid, m_axi_rready;
   logic [31:0] m_axi_rdata;
   logic [1:0]  m_axi_rresp;

   always #5 clk = ~clk;

   iob_native_axil_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .reset(reset), .valid(valid), .addr(addr), .wdata(wdata), .wstrb(wstrb),
      .rdata(rdata), .ready(ready), .resp_err(resp_err),
      .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_awaddr(m_axi_awaddr),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata),
      .m_axi_wstrb(m_axi_wstrb), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
      .m_axi_bresp(m_axi_bresp), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_araddr(m_axi_araddr), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp)
   );

   typedef struct {bit is_wr; logic [31:0] rdata; bit err;} exp_t;
   typedef struct {bit is_wr; logic [31:0] addr; logic [31:0] data; logic [3:0] strb;} axi_t;

   int          checks = 0;
   int          failures = 0;
   exp_t        exp_q[$];
   axi_t        axi_q[$];
   logic [1:0]  resp_q[$];
   logic [31:0] slave_mem[int];
   logic [31:0] model_mem[int];
   logic [31:0] last_read = '0;
   int          aw_fix = 0, w_fix = 0, b_fix = 0, ar_fix = 0, r_fix = 0;
   int          aw_cyc = 0, w_cyc = 0, bready_early = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic logic [31:0] def_word(input int idx);
      return 32'(idx) * 32'h9E3779B1 ^ 32'h5A5A0F0F;
   endfunction

   function automatic logic [31:0] model_read(input int idx);
      if (model_mem.exists(idx)) return model_mem[idx];
      return def_word(idx);
   endfunction

   function automatic logic [31:0] slave_read(input int idx);
      if (slave_mem.exists(idx)) return slave_mem[idx];
      return def_word(idx);
   endfunction

   function automatic int pick(input int fix);
      if (fix >= 0) return fix;
      if ($urandom_range(0, 5) == 0) return int'($urandom_range(4, 9));
      return int'($urandom_range(0, 2));
   endfunction

   // AXI4-Lite slave: random/fixed ready and response delays, memory, channel checks
   initial begin : slave
      bit          aw_hs, w_hs, b_hs, ar_hs, r_hs, got_aw, got_w, b_pend, r_pend;
      bit          aw_wait, w_wait, ar_wait;
      int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt, aw_d, w_d, ar_d, b_d, r_d;
      logic [31:0] aw_a, w_data, ar_a, aw_prev, w_prev_d, ar_prev, word;
      logic [3:0]  w_strb, w_prev_s;
      m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
      m_axi_bvalid = 0; m_axi_bresp = 0; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            {aw_hs, w_hs, b_hs, ar_hs, r_hs, got_aw, got_w, b_pend, r_pend} = '0;
            {aw_wait, w_wait, ar_wait} = '0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
            m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
            m_axi_bvalid = 0; m_axi_rvalid = 0;
            continue;
         end
         if (aw_wait) begin
            check("awvalid_held", m_axi_awvalid, 1);
            check("awaddr_stable", m_axi_awaddr, aw_prev);
         end
         if (w_wait) begin
            check("wvalid_held", m_axi_wvalid, 1);
            check("wdata_stable", {m_axi_wstrb, m_axi_wdata}, {w_prev_s, w_prev_d});
         end
         if (ar_wait) begin
            check("arvalid_held", m_axi_arvalid, 1);
            check("araddr_stable", m_axi_araddr, ar_prev);
         end
         if (m_axi_awvalid) aw_cyc++;
         if (m_axi_wvalid) w_cyc++;
         if (m_axi_bready && (m_axi_awvalid || m_axi_wvalid)) bready_early++;
         if (aw_hs) begin
            check("aw_expected", axi_q.size() > 0 && axi_q[0].is_wr, 1);
            if (axi_q.size() > 0) check("awaddr", aw_a, axi_q[0].addr);
            got_aw = 1; aw_cnt = 0;
         end
         if (w_hs) begin
            check("w_expected", axi_q.size() > 0 && axi_q[0].is_wr, 1);
            if (axi_q.size() > 0) check("wdata_wstrb", {w_strb, w_data}, {axi_q[0].strb, axi_q[0].data});
            got_w = 1; w_cnt = 0;
         end
         if (got_aw && got_w) begin
            word = slave_read(int'(aw_a >> 2));
            for (int b = 0; b < 4; b++) if (w_strb[b]) word[8*b +: 8] = w_data[8*b +: 8];
            slave_mem[int'(aw_a >> 2)] = word;
            if (axi_q.size() > 0) void'(axi_q.pop_front());
            got_aw = 0; got_w = 0; b_pend = 1; b_cnt = 0; b_d = pick(b_fix);
         end
         if (b_hs) m_axi_bvalid = 0;
         if (ar_hs) begin
            check("ar_expected", axi_q.size() > 0 && !axi_q[0].is_wr, 1);
            if (axi_q.size() > 0) begin
               check("araddr", ar_a, axi_q[0].addr);
               void'(axi_q.pop_front());
            end
            ar_cnt = 0; r_pend = 1; r_cnt = 0; r_d = pick(r_fix);
         end
         if (r_hs) m_axi_rvalid = 0;
         if (m_axi_awvalid) begin
            if (aw_cnt == 0) aw_d = pick(aw_fix);
            m_axi_awready = (aw_cnt >= aw_d); aw_cnt++;
         end else m_axi_awready = 0;
         if (m_axi_wvalid) begin
            if (w_cnt == 0) w_d = pick(w_fix);
            m_axi_wready = (w_cnt >= w_d); w_cnt++;
         end else m_axi_wready = 0;
         if (m_axi_arvalid) begin
            if (ar_cnt == 0) ar_d = pick(ar_fix);
            m_axi_arready = (ar_cnt >= ar_d); ar_cnt++;
         end else m_axi_arready = 0;
         if (b_pend) begin
            if (b_cnt >= b_d) begin
               m_axi_bvalid = 1; m_axi_bresp = (resp_q.size() > 0) ? resp_q.pop_front() : 2'd0; b_pend = 0;
            end else b_cnt++;
         end
         if (r_pend) begin
            if (r_cnt >= r_d) begin
               m_axi_rvalid = 1; m_axi_rdata = slave_read(int'(ar_a >> 2));
               m_axi_rresp = (resp_q.size() > 0) ? resp_q.pop_front() : 2'd0; r_pend = 0;
            end else r_cnt++;
         end
         aw_hs = m_axi_awvalid && m_axi_awready; aw_a = m_axi_awaddr;
         w_hs = m_axi_wvalid && m_axi_wready; w_data = m_axi_wdata; w_strb = m_axi_wstrb;
         if (m_axi_arvalid && m_axi_arready) ar_a = m_axi_araddr;
         ar_hs = m_axi_arvalid && m_axi_arready;
         b_hs = m_axi_bvalid && m_axi_bready;
         r_hs = m_axi_rvalid && m_axi_rready;
         aw_wait = m_axi_awvalid && !m_axi_awready; aw_prev = m_axi_awaddr;
         w_wait = m_axi_wvalid && !m_axi_wready; w_prev_d = m_axi_wdata; w_prev_s = m_axi_wstrb;
         ar_wait = m_axi_arvalid && !m_axi_arready; ar_prev = m_axi_araddr;
      end
   end

   // Monitor: every ready pulse pops one expected completion
   initial begin : monitor
      logic prev_ready = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset && ready) begin
            check("ready_single_pulse", prev_ready, 0);
            check("ready_has_expectation", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check(e.is_wr ? "write_resp_err" : "read_resp_err", resp_err, e.err);
               check(e.is_wr ? "rdata_held_on_write" : "read_rdata", rdata, e.rdata);
            end
         end
         prev_ready = ready;
      end
   end

   task automatic issue_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] rs);
      exp_t        e;
      axi_t        x;
      int          idx;
      logic [31:0] w;
      idx = int'(a >> 2);
      x.is_wr = (s != 0); x.addr = a & ~32'h3; x.data = d; x.strb = s;
      e.is_wr = x.is_wr; e.err = (rs != 0);
      if (x.is_wr) begin
         w = model_read(idx);
         for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
         model_mem[idx] = w;
         e.rdata = last_read;
      end else begin
         e.rdata = model_read(idx);
         last_read = e.rdata;
      end
      exp_q.push_back(e); axi_q.push_back(x); resp_q.push_back(rs);
      valid = 1; addr = a; wdata = d; wstrb = s;
   endtask

   task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] rs, output int lat);
      issue_req(a, d, s, rs);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!ready && lat < 300);
      check("ready_within_bound", ready, 1);
   endtask

   task automatic check_zero(input string name);
      check({name, "_ctrl"}, {ready, resp_err, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 0);
      check({name, "_rdata"}, rdata, 0);
      check({name, "_payload"}, m_axi_awaddr | m_axi_araddr | m_axi_wdata | 32'(m_axi_wstrb), 0);
   endtask

   task automatic set_fix(input int v);
      aw_fix = v; w_fix = v; b_fix = v; ar_fix = v; r_fix = v;
   endtask

   initial begin : stim
      int lat, n;
      logic [3:0] s;
      reset = 0; valid = 0; addr = 0; wdata = 0; wstrb = 0;
      repeat (2) @(negedge clk);
      check_zero("reset_state");
      reset = 1;
      @(negedge clk);

      set_fix(0);
      slave_mem[32'h400] = 32'hCAFEF00D; model_mem[32'h400] = 32'hCAFEF00D;
      do_req(32'h1003, $urandom, 4'h0, 2'd0, lat);
      check("read_latency", lat, 3);
      check("read_rdata_direct", rdata, 32'hCAFEF00D);
      valid = 0; @(negedge clk);

      aw_fix = 4; aw_cyc = 0; w_cyc = 0; bready_early = 0;
      do_req(32'h20, 32'h12345678, 4'h3, 2'd0, lat);
      check("aw_delay_awvalid_cycles", aw_cyc, 5);
      check("aw_delay_wvalid_cycles", w_cyc, 1);
      check("bready_before_both", bready_early, 0);
      check("aw_delay_latency", lat, 7);
      valid = 0; @(negedge clk);

      aw_fix = 3;
      do_req(32'h44, $urandom, 4'hF, 2'd2, lat);
      valid = 0; @(negedge clk);
      aw_fix = 0;
      do_req(32'h44, 32'h0, 4'h0, 2'd0, lat);

      do_req(32'h20, 32'h0, 4'h0, 2'd0, lat);
      do_req(32'h24, 32'hA1B2C3D4, 4'hC, 2'd0, lat);
      check("b2b_write_latency", lat, 4);
      do_req(32'h24, 32'h0, 4'h0, 2'd0, lat);
      check("b2b_read_latency", lat, 4);
      valid = 0; @(negedge clk);

      set_fix(-1);
      for (int i = 0; i < 60; i++) begin
         n = int'($urandom_range(0, 2));
         if (n > 0) begin
            valid = 0;
            repeat (n) @(negedge clk);
         end
         s = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
         do_req(32'h100 + 32'($urandom_range(0, 31)), $urandom, s,
                ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0, lat);
      end
      valid = 0; @(negedge clk);

      set_fix(0); r_fix = 3;
      issue_req(32'h1003, 32'h0, 4'h0, 2'd0);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(m_axi_rvalid && m_axi_rready) && n < 50);
      check("reset_test_rvalid_pending", m_axi_rvalid && m_axi_rready, 1);
      #2 reset = 0;
      #1 check_zero("reset_mid_rdata");
      exp_q.delete(); axi_q.delete(); resp_q.delete();
      last_read = '0; valid = 0;
      repeat (2) @(negedge clk);
      reset = 1; r_fix = 0;
      @(negedge clk);
      do_req(32'h1003, 32'h0, 4'h0, 2'd0, lat);
      check("post_reset_read_latency", lat, 3);
      check("post_reset_rdata", rdata, 32'hCAFEF00D);
      valid = 0;
      repeat (4) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 0);
      check("axi_expectations_drained", axi_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
